// File: rtl/sm_serial_accumulator.sv
// rtl/sm_serial_accumulator.sv - bit-serial sign-magnitude totaliser with sticky overflow
// Optional saturation on overflow is enabled by defining SM_ACC_SAT_EN.
module sm_serial_accumulator #(
  parameter int MAG_W = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             clear,
  output logic             acc_sign,
  output logic [ACC_W-1:0] acc_mag,
  output logic             acc_valid,
  output logic             ovf
);

  localparam int CNT_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam logic [ACC_W-1:0] ONE     = ACC_W'(1);
  localparam logic [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(ACC_W-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] opnd_q, opnd_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             opnd_sign_q, opnd_sign_d;
  logic             old_sign_q, old_sign_d;
  logic             acc_sign_q, acc_sign_d;
  logic [ACC_W-1:0] acc_mag_q, acc_mag_d;
  logic             acc_valid_q, acc_valid_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W-1:0] opnd_conv;
  logic             sum_bit;
  logic             carry_nxt;
  logic             overflow;
  logic [ACC_W-1:0] fin_val;

  assign in_ready = (state_q == IDLE) && !clear;

  // Negating a zero magnitude yields zero, so negative zero needs no special case.
  assign mag_ext   = {{(ACC_W-MAG_W){1'b0}}, in_mag};
  assign opnd_conv = in_sign ? (~mag_ext + ONE) : mag_ext;

  assign sum_bit   = opnd_q[0] ^ acc_q[0] ^ carry_q;
  assign carry_nxt = (opnd_q[0] & acc_q[0]) | (opnd_q[0] & carry_q) | (acc_q[0] & carry_q);

  assign overflow = (opnd_sign_q == old_sign_q) && (acc_q[ACC_W-1] != opnd_sign_q);

  always_comb begin
    fin_val = acc_q;
`ifdef SM_ACC_SAT_EN
    if (overflow) begin
      fin_val = opnd_sign_q ? SAT_NEG : SAT_POS;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    opnd_sign_d = opnd_sign_q;
    old_sign_d  = old_sign_q;
    acc_sign_d  = acc_sign_q;
    acc_mag_d   = acc_mag_q;
    acc_valid_d = 1'b0;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          opnd_d      = opnd_conv;
          opnd_sign_d = opnd_conv[ACC_W-1];
          old_sign_d  = acc_q[ACC_W-1];
          carry_d     = 1'b0;
          cnt_d       = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        // Sum bits enter at the MSB so the accumulator rotates into place after ACC_W steps.
        acc_d   = {sum_bit, acc_q[ACC_W-1:1]};
        opnd_d  = {1'b0, opnd_q[ACC_W-1:1]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = FIN;
        end
      end
      FIN: begin
        ovf_d       = ovf_q | overflow;
        acc_d       = fin_val;
        acc_sign_d  = fin_val[ACC_W-1];
        acc_mag_d   = fin_val[ACC_W-1] ? (~fin_val + ONE) : fin_val;
        acc_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      carry_d     = 1'b0;
      acc_sign_d  = 1'b0;
      acc_mag_d   = '0;
      acc_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      opnd_sign_q <= 1'b0;
      old_sign_q  <= 1'b0;
      acc_sign_q  <= 1'b0;
      acc_mag_q   <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      opnd_sign_q <= opnd_sign_d;
      old_sign_q  <= old_sign_d;
      acc_sign_q  <= acc_sign_d;
      acc_mag_q   <= acc_mag_d;
      acc_valid_q <= acc_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign acc_sign  = acc_sign_q;
  assign acc_mag   = acc_mag_q;
  assign acc_valid = acc_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sm_serial_accumulator.sv
// tb/tb_sm_serial_accumulator.sv - directed scoreboard bench for sm_serial_accumulator
// Expected totals follow SM_ACC_SAT_EN when the bench is built with it defined.
module tb_sm_serial_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [3:0] in_mag;
  logic       clear;
  logic       acc_sign;
  logic [7:0] acc_mag;
  logic       acc_valid;
  logic       ovf;

  sm_serial_accumulator #(.MAG_W(4), .ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_mag(in_mag), .clear(clear), .acc_sign(acc_sign),
    .acc_mag(acc_mag), .acc_valid(acc_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sign;
    logic [7:0] mag;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   m_acc = 0;
  bit   m_ovf = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_push(input logic s, input logic [3:0] m);
    int v;
    int sum;
    exp_t e;
    v   = s ? -int'(m) : int'(m);
    sum = m_acc + v;
    if (sum > 127 || sum < -128) begin
      m_ovf = 1'b1;
`ifdef SM_ACC_SAT_EN
      sum = (sum > 127) ? 127 : -128;
`else
      sum = (sum > 127) ? sum - 256 : sum + 256;
`endif
    end
    m_acc  = sum;
    e.sign = (sum < 0);
    e.mag  = 8'((sum < 0) ? -sum : sum);
    e.ovf  = m_ovf;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_ovf = 1'b0;
  endtask

  task automatic send(input logic s, input logic [3:0] m);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_sign  = s;
      in_mag   = m;
      in_valid = 1'b1;
      model_push(s, m);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("idle_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_reset();
  endtask

  // Scoreboard: every acc_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && acc_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(acc_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("acc_sign", 32'(acc_sign), 32'(e.sign));
        chk("acc_mag", 32'(acc_mag), 32'(e.mag));
        chk("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_mag = 4'd0; clear = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_acc_mag", 32'(acc_mag), 32'd0);
    chk("rst_acc_valid", 32'(acc_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a SHIFT sequence
    send(1'b0, 4'd9);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_acc_sign", 32'(acc_sign), 32'd0);
    chk("midrst_acc_mag", 32'(acc_mag), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_acc_valid", 32'(acc_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 4'd3);
    wait_idle();

    // Mixed signs with a latency/handshake probe on the second operand
    do_clear();
    send(1'b0, 4'd5);
    wait_idle();
    @(negedge clk);
    in_sign = 1'b1; in_mag = 4'd7; in_valid = 1'b1;
    model_push(1'b1, 4'd7);
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("ready_low_busy", 32'(in_ready), 32'd0);
      chk("no_early_valid", 32'(acc_valid), 32'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("valid_after_fin", 32'(acc_valid), 32'd1);
    chk("ready_after_fin", 32'(in_ready), 32'd1);
    chk("mixed_sign", 32'(acc_sign), 32'd1);
    chk("mixed_mag", 32'(acc_mag), 32'd2);
    @(negedge clk);
    chk("valid_one_cycle", 32'(acc_valid), 32'd0);
    chk("mag_holds", 32'(acc_mag), 32'd2);
    wait_idle();

    // Negative zero
    do_clear();
    send(1'b0, 4'd4);
    send(1'b1, 4'd0);
    wait_idle();

    // Positive overflow, then ovf stickiness
    do_clear();
    for (int i = 0; i < 9; i++) send(1'b0, 4'd15);
    send(1'b1, 4'd15);
    wait_idle();
    chk("pos_ovf_sticky", 32'(ovf), 32'd1);

    // Negative overflow
    do_clear();
    for (int i = 0; i < 9; i++) send(1'b1, 4'd15);
    wait_idle();

    // Clear during the 4th SHIFT step drops the operation
    do_clear();
    chk("clear_zero_mag", 32'(acc_mag), 32'd0);
    chk("clear_zero_ovf", 32'(ovf), 32'd0);
    send(1'b0, 4'd10);
    wait_idle();
    send(1'b0, 4'd6);
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    void'(q.pop_back());
    model_reset();
    @(negedge clk);
    chk("abort_no_valid", 32'(acc_valid), 32'd0);
    chk("abort_mag", 32'(acc_mag), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    repeat (12) @(negedge clk);

    // clear together with in_valid in IDLE accepts nothing
    in_sign = 1'b0; in_mag = 4'd5; in_valid = 1'b1; clear = 1'b1;
    #1 chk("clear_blocks_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 begin in_valid = 1'b0; clear = 1'b0; end
    @(negedge clk);
    chk("clear_idle_ready", 32'(in_ready), 32'd1);
    repeat (12) @(negedge clk);
    chk("clear_idle_mag", 32'(acc_mag), 32'd0);

    // Accumulation resumes from zero after the abort
    send(1'b0, 4'd2);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
